// File: rtl/core_pipe_wb_q.sv
// Queued writeback stage: holds in-flight instructions, pairs LSU entries with
// in-order dmem responses, retires one per cycle in order and raises precise traps.
module core_pipe_wb_q #(
    parameter int XLEN     = 64,
    parameter int DEPTH    = 4,
    parameter int CAUSE_W  = 6,
    parameter int LD_FAULT = 5,
    parameter int ST_FAULT = 7
) (
    input  logic               g_clk,
    input  logic               g_resetn,
    input  logic               s3_valid,
    output logic               s3_ready,
    input  logic [XLEN-1:0]    s3_pc,
    input  logic [31:0]        s3_instr,
    input  logic [4:0]         s3_rd,
    input  logic [XLEN-1:0]    s3_wdata,
    input  logic               s3_wen,
    input  logic [6:0]         s3_lsu_op,
    input  logic               s3_trap,
    input  logic [CAUSE_W-1:0] s3_cause,
    input  logic               dmem_rsp,
    input  logic               dmem_err,
    input  logic [XLEN-1:0]    dmem_rdata,
    input  logic [XLEN-1:0]    mtvec_base,
    output logic               rd_wen,
    output logic [4:0]         rd_addr,
    output logic [XLEN-1:0]    rd_wdata,
    output logic               instr_ret,
    output logic [XLEN-1:0]    trs_pc,
    output logic [31:0]        trs_instr,
    output logic               cf_valid,
    input  logic               cf_ack,
    output logic [XLEN-1:0]    cf_target,
    output logic               trap_cpu,
    output logic [CAUSE_W-1:0] trap_cause,
    output logic [XLEN-1:0]    trap_pc,
    output logic [XLEN-1:0]    trap_mtval
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int AW = $clog2(XLEN / 8);

    typedef enum logic [1:0] {ST_RUN, ST_TRAP, ST_DRAIN} state_t;

    // op = {sext,double,word,half,byte,store,load}
    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [31:0]        instr;
        logic [4:0]         rd;
        logic [XLEN-1:0]    wdata;
        logic               wen;
        logic [6:0]         op;
        logic               trap;
        logic [CAUSE_W-1:0] cause;
        logic               done;
        logic               err;
        logic [XLEN-1:0]    rdata;
    } entry_t;

    // A trapping instruction never reached memory, so it owes no response.
    function automatic logic is_lsu(input entry_t e);
        return (e.op[0] | e.op[1]) & ~e.trap;
    endfunction

    entry_t             r_q [DEPTH];
    logic [PW-1:0]      r_head, r_tail;
    logic [CW-1:0]      r_count, r_owed;
    state_t             r_state;
    logic               r_ret, r_rd_wen, r_cf_valid;
    logic [4:0]         r_rd_addr;
    logic [XLEN-1:0]    r_rd_wdata, r_trs_pc, r_trap_pc, r_trap_mtval;
    logic [31:0]        r_trs_instr;
    logic [CAUSE_W-1:0] r_trap_cause;

    entry_t             w_hd;
    logic               w_hd_ready, w_fault, w_ret, w_take_trap, w_ack;
    logic               w_enq, w_enq_lsu, w_rsp, w_rp_found;
    logic [PW-1:0]      w_rp;
    logic [CW-1:0]      w_owed_nxt;
    logic [XLEN-1:0]    w_shift, w_ld;

    assign w_hd        = r_q[r_head];
    assign w_hd_ready  = (r_count != '0) && (!is_lsu(w_hd) || w_hd.done);
    assign w_fault     = w_hd.trap || w_hd.err;
    assign w_ret       = (r_state == ST_RUN) && w_hd_ready && !w_fault;
    assign w_take_trap = (r_state == ST_RUN) && w_hd_ready && w_fault;
    assign w_ack       = r_cf_valid && cf_ack;
    assign w_enq       = s3_valid && s3_ready;
    assign w_enq_lsu   = w_enq && (s3_lsu_op[0] || s3_lsu_op[1]) && !s3_trap;
    assign w_rsp       = dmem_rsp && (r_owed != '0);
    assign w_owed_nxt  = r_owed + CW'(w_enq_lsu) - CW'(w_rsp);

    // Responses arrive in order, so the oldest queued LSU entry still waiting owns the next one.
    always_comb begin
        w_rp       = r_head;
        w_rp_found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!w_rp_found && (CW'(i) < r_count) && is_lsu(r_q[r_head + PW'(i)])
                && !r_q[r_head + PW'(i)].done) begin
                w_rp       = r_head + PW'(i);
                w_rp_found = 1'b1;
            end
        end
    end

    always_comb begin
        w_shift = w_hd.rdata >> {w_hd.wdata[AW-1:0], 3'b000};
        if (w_hd.op[2])
            w_ld = w_hd.op[6] ? XLEN'($signed(w_shift[7:0])) : XLEN'(w_shift[7:0]);
        else if (w_hd.op[3])
            w_ld = w_hd.op[6] ? XLEN'($signed(w_shift[15:0])) : XLEN'(w_shift[15:0]);
        else if (w_hd.op[4])
            w_ld = w_hd.op[6] ? XLEN'($signed(w_shift[31:0])) : XLEN'(w_shift[31:0]);
        else
            w_ld = w_shift;
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            for (int i = 0; i < DEPTH; i++) r_q[i] <= '0;
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_owed       <= '0;
            r_state      <= ST_RUN;
            r_ret        <= 1'b0;
            r_rd_wen     <= 1'b0;
            r_rd_addr    <= '0;
            r_rd_wdata   <= '0;
            r_trs_pc     <= '0;
            r_trs_instr  <= '0;
            r_cf_valid   <= 1'b0;
            r_trap_cause <= '0;
            r_trap_pc    <= '0;
            r_trap_mtval <= '0;
        end else begin
            r_ret    <= 1'b0;
            r_rd_wen <= 1'b0;
            r_owed   <= w_owed_nxt;
            r_count  <= r_count + CW'(w_enq) - CW'(w_ret);
            r_head   <= r_head + PW'(w_ret);
            if (w_rsp && w_rp_found) begin
                r_q[w_rp].done  <= 1'b1;
                r_q[w_rp].err   <= dmem_err;
                r_q[w_rp].rdata <= dmem_rdata;
            end
            if (w_enq) begin
                r_q[r_tail] <= '{pc: s3_pc, instr: s3_instr, rd: s3_rd, wdata: s3_wdata,
                                 wen: s3_wen, op: s3_lsu_op, trap: s3_trap, cause: s3_cause,
                                 done: 1'b0, err: 1'b0, rdata: '0};
                r_tail      <= r_tail + 1'b1;
            end
            case (r_state)
                ST_RUN: begin
                    if (w_ret) begin
                        r_ret       <= 1'b1;
                        r_trs_pc    <= w_hd.pc;
                        r_trs_instr <= w_hd.instr;
                        r_rd_wen    <= (w_hd.wen || w_hd.op[0]) && (w_hd.rd != 5'd0);
                        r_rd_addr   <= w_hd.rd;
                        r_rd_wdata  <= w_hd.op[0] ? w_ld : w_hd.wdata;
                    end else if (w_take_trap) begin
                        r_state      <= ST_TRAP;
                        r_cf_valid   <= 1'b1;
                        r_trs_pc     <= w_hd.pc;
                        r_trs_instr  <= w_hd.instr;
                        r_trap_pc    <= w_hd.pc;
                        r_trap_cause <= w_hd.trap ? w_hd.cause :
                                        (w_hd.op[0] ? CAUSE_W'(LD_FAULT) : CAUSE_W'(ST_FAULT));
                        r_trap_mtval <= w_hd.err ? w_hd.wdata : '0;
                    end
                end
                ST_TRAP: begin
                    // The trapping head and everything younger are dropped on acceptance.
                    if (cf_ack) begin
                        r_cf_valid <= 1'b0;
                        r_head     <= r_tail;
                        r_count    <= '0;
                        r_state    <= (w_owed_nxt != '0) ? ST_DRAIN : ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    if (w_owed_nxt == '0) r_state <= ST_RUN;
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    assign s3_ready   = (r_count < CW'(DEPTH)) && (r_state == ST_RUN);
    assign instr_ret  = r_ret || w_ack;
    assign trap_cpu   = w_ack;
    assign rd_wen     = r_rd_wen;
    assign rd_addr    = r_rd_addr;
    assign rd_wdata   = r_rd_wdata;
    assign trs_pc     = r_trs_pc;
    assign trs_instr  = r_trs_instr;
    assign cf_valid   = r_cf_valid;
    assign cf_target  = mtvec_base;
    assign trap_cause = r_trap_cause;
    assign trap_pc    = r_trap_pc;
    assign trap_mtval = r_trap_mtval;

    assert property (@(posedge g_clk) disable iff (!g_resetn) dmem_rsp |-> (r_owed != '0));
    assert property (@(posedge g_clk) disable iff (!g_resetn) !(w_enq_lsu && !w_rsp && (&r_owed)));
endmodule
